imem_loader: RTL and testbench

//  Fills the MIPS instruction memory from a byte stream (valid/ready handshake) before execution.

---
 rtl/imem_loader.sv | 130 +++++++++++++
 tb/tb_imem_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream loader for the MIPS instruction memory: packs big-endian bytes into
// 32-bit words, writes them from address 0 upward and holds the CPU until the last word lands.
module imem_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int WORDS      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  typedef enum logic [1:0] {
    ST_RECV  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam int                  LAST_IDX_I = WORDS - 1;
  localparam logic [ADDR_WIDTH:0] LAST_IDX   = LAST_IDX_I[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state_r;
  state_t                state_s;
  logic [1:0]            byte_cnt_r;
  logic [23:0]           asm_r;
  logic                  last_r;
  logic                  xfer_s;
  logic                  imem_we_r;
  logic [ADDR_WIDTH-1:0] imem_addr_r;
  logic [31:0]           imem_wdata_r;
  logic                  cpu_hold_r;
  logic                  done_r;
  logic                  error_r;
  logic [ADDR_WIDTH:0]   word_count_r;

  assign in_ready   = (state_r == ST_RECV);
  assign xfer_s     = in_valid & in_ready;
  assign imem_we    = imem_we_r;
  assign imem_addr  = imem_addr_r;
  assign imem_wdata = imem_wdata_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign error      = error_r;
  assign word_count = word_count_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RECV;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode; overflow is judged on the pointer of the word being written
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_RECV: begin
        if (xfer_s && (byte_cnt_r == 2'd3)) begin
          state_s = ST_WRITE;
        end else if (xfer_s && in_last) begin
          state_s = ST_ERROR;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_WRITE: begin
        if (last_r) begin
          state_s = ST_DONE;
        end else if (word_count_r == LAST_IDX) begin
          state_s = ST_ERROR;
        end else begin
          state_s = ST_RECV;
        end
      end
      ST_DONE:  state_s = ST_DONE;
      ST_ERROR: state_s = ST_ERROR;
      default:  state_s = ST_ERROR;
    endcase
  end

  // Byte assembly, write port and status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_r   <= 2'd0;
      asm_r        <= 24'd0;
      last_r       <= 1'b0;
      imem_we_r    <= 1'b0;
      imem_addr_r  <= {ADDR_WIDTH{1'b0}};
      imem_wdata_r <= 32'd0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      word_count_r <= {(ADDR_WIDTH + 1){1'b0}};
    end else begin
      imem_we_r <= 1'b0;
      if (xfer_s) begin
        asm_r      <= {asm_r[15:0], in_data};
        byte_cnt_r <= byte_cnt_r + 2'd1;
        // The fourth byte goes straight into the write register, so the strobe
        // and its address/data all appear together in the WRITE cycle.
        if (byte_cnt_r == 2'd3) begin
          last_r       <= in_last;
          imem_we_r    <= 1'b1;
          imem_addr_r  <= word_count_r[ADDR_WIDTH-1:0];
          imem_wdata_r <= {asm_r, in_data};
        end
      end
      if (state_r == ST_WRITE) begin
        word_count_r <= word_count_r + CNT_ONE;
      end
      cpu_hold_r <= (state_s != ST_DONE);
      done_r     <= (state_s == ST_DONE);
      error_r    <= (state_s == ST_ERROR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a per-cycle vector table for the back-to-back
// stream plus short sequences for gaps, truncation, overflow and mid-stream reset.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, in_ready, imem_we, cpu_hold, done, error;
  logic [7:0]  in_data, imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  logic        s_valid, s_last, s_ready, s_we, s_hold, s_done, s_error;
  logic [7:0]  s_data, s_addr;
  logic [31:0] s_wdata;
  logic [8:0]  s_count;

  int checks = 0;
  int errors = 0;

  imem_loader #(.ADDR_WIDTH(8), .WORDS(256)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
  );

  imem_loader #(.ADDR_WIDTH(8), .WORDS(4)) u_small (
    .clk(clk), .rst(rst), .in_valid(s_valid), .in_data(s_data), .in_last(s_last),
    .in_ready(s_ready), .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
    .cpu_hold(s_hold), .done(s_done), .error(s_error), .word_count(s_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [7:0]  data;
    logic        last;
    logic        ready;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        hold;
    logic        done;
    logic        err;
    logic [8:0]  wc;
  } vec_t;

  vec_t        vecs[$];
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0]  s_wr_addr[$];
  logic [31:0] s_wr_data[$];

  function automatic vec_t mk(logic v, logic [7:0] d, logic l, logic rdy, logic we,
                              logic [7:0] a, logic [31:0] w, logic h, logic dn,
                              logic er, logic [8:0] wc);
    vec_t t;
    t.valid = v; t.data = d; t.last = l; t.ready = rdy; t.we = we; t.addr = a;
    t.wdata = w; t.hold = h; t.done = dn; t.err = er; t.wc = wc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge and writes logged.
  task automatic step();
    @(posedge clk);
    #1;
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wdata);
    end
    if (s_we === 1'b1) begin
      s_wr_addr.push_back(s_addr);
      s_wr_data.push_back(s_wdata);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    step();
    step();
    rst = 1'b0;
    wr_addr.delete(); wr_data.delete();
    s_wr_addr.delete(); s_wr_data.delete();
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_rst_we"},    32'(imem_we),    32'd0);
    chk({tag, "_rst_addr"},  32'(imem_addr),  32'd0);
    chk({tag, "_rst_wdata"}, imem_wdata,      32'd0);
    chk({tag, "_rst_hold"},  32'(cpu_hold),   32'd1);
    chk({tag, "_rst_ready"}, 32'(in_ready),   32'd1);
    chk({tag, "_rst_flags"}, {30'd0, done, error}, 32'd0);
    chk({tag, "_rst_wc"},    32'(word_count), 32'd0);
  endtask

  // Offer one byte until accepted (bounded), then idle for gap cycles with in_last noise.
  task automatic send(input logic [7:0] d, input logic l, input int gap);
    logic acc;
    int   n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!acc && n < 20) begin
      acc = in_ready;
      step();
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
    in_last  = 1'b1;
    for (int g = 0; g < gap; g++) step();
    in_last  = 1'b0;
  endtask

  logic [7:0] prog[8];
  int         k, we_cyc, err_cyc;

  initial begin
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};

    // Back-to-back stream; valid stays high across both WRITE cycles
    vecs.push_back(mk(1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    vecs.push_back(mk(1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 32'h0,        1'b1, 1'b0, 1'b0, 9'd0));
    vecs.push_back(mk(1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'd0, 32'h20080005, 1'b1, 1'b0, 1'b0, 9'd0));
    vecs.push_back(mk(1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'd0, 32'h20080005, 1'b1, 1'b0, 1'b0, 9'd1));
    vecs.push_back(mk(1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 8'd0, 32'h20080005, 1'b1, 1'b0, 1'b0, 9'd1));
    vecs.push_back(mk(1'b1, 8'h09, 1'b0, 1'b1, 1'b0, 8'd0, 32'h20080005, 1'b1, 1'b0, 1'b0, 9'd1));
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'd0, 32'h20080005, 1'b1, 1'b0, 1'b0, 9'd1));
    vecs.push_back(mk(1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 8'd1, 32'h2009000A, 1'b1, 1'b0, 1'b0, 9'd1));
    vecs.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, 32'h2009000A, 1'b0, 1'b1, 1'b0, 9'd2));
    vecs.push_back(mk(1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'd1, 32'h2009000A, 1'b0, 1'b1, 1'b0, 9'd2));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, 32'h2009000A, 1'b0, 1'b1, 1'b0, 9'd2));

    do_reset();
    chk_reset_state("t1");
    foreach (vecs[i]) begin
      in_valid = vecs[i].valid; in_data = vecs[i].data; in_last = vecs[i].last;
      #1;
      chk($sformatf("t1_v%0d_ready", i), 32'(in_ready), 32'(vecs[i].ready));
      step();
      chk($sformatf("t1_v%0d_we", i),    32'(imem_we),    32'(vecs[i].we));
      chk($sformatf("t1_v%0d_addr", i),  32'(imem_addr),  32'(vecs[i].addr));
      chk($sformatf("t1_v%0d_wdata", i), imem_wdata,      vecs[i].wdata);
      chk($sformatf("t1_v%0d_hold", i),  32'(cpu_hold),   32'(vecs[i].hold));
      chk($sformatf("t1_v%0d_done", i),  32'(done),       32'(vecs[i].done));
      chk($sformatf("t1_v%0d_err", i),   32'(error),      32'(vecs[i].err));
      chk($sformatf("t1_v%0d_wc", i),    32'(word_count), 32'(vecs[i].wc));
    end
    in_valid = 1'b0; in_last = 1'b0;

    // Idle gaps of 1..3 cycles between bytes
    do_reset();
    chk_reset_state("t2");
    for (int i = 0; i < 8; i++) send(prog[i], (i == 7), 1 + (i % 3));
    step();
    chk("t2_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      chk("t2_addr0", 32'(wr_addr[0]), 32'd0);
      chk("t2_data0", wr_data[0], 32'h20080005);
      chk("t2_addr1", 32'(wr_addr[1]), 32'd1);
      chk("t2_data1", wr_data[1], 32'h2009000A);
    end
    chk("t2_done", {30'd0, done, error}, 32'd2);
    chk("t2_hold", 32'(cpu_hold), 32'd0);
    chk("t2_wc",   32'(word_count), 32'd2);

    // Truncated word
    do_reset();
    send(8'h8C, 1'b0, 0);
    send(8'h01, 1'b0, 0);
    send(8'h00, 1'b1, 1);
    chk("t3_nwrites", 32'(wr_addr.size()), 32'd0);
    chk("t3_flags", {30'd0, done, error}, 32'd1);
    chk("t3_hold", 32'(cpu_hold), 32'd1);
    in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0;
    #1;
    chk("t3_ready", 32'(in_ready), 32'd0);
    step(); step();
    chk("t3_wc", 32'(word_count), 32'd0);
    chk("t3_nwrites_late", 32'(wr_addr.size()), 32'd0);
    in_valid = 1'b0;

    // Overflow on the 4-word instance: 20 bytes offered, none marked last
    do_reset();
    k = 0; we_cyc = -1; err_cyc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      logic acc;
      s_valid = (k < 20);
      s_data  = 8'(8'h10 + k);
      s_last  = 1'b0;
      #1;
      acc = s_ready & s_valid;
      step();
      if (acc) k++;
      if (s_we === 1'b1) we_cyc = cyc;
      if (s_error === 1'b1 && err_cyc < 0) err_cyc = cyc;
    end
    s_valid = 1'b0;
    chk("t4_accepted", 32'(k), 32'd16);
    chk("t4_nwrites", 32'(s_wr_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (s_wr_addr.size() > i) begin
        chk($sformatf("t4_addr%0d", i), 32'(s_wr_addr[i]), 32'(i));
        chk($sformatf("t4_data%0d", i), s_wr_data[i],
            {8'(16 + 4*i), 8'(17 + 4*i), 8'(18 + 4*i), 8'(19 + 4*i)});
      end
    end
    chk("t4_err_timing", 32'(err_cyc), 32'(we_cyc + 1));
    chk("t4_flags", {29'd0, s_hold, s_done, s_error}, 32'd5);
    chk("t4_wc", 32'(s_count), 32'd4);
    chk("t4_ready", 32'(s_ready), 32'd0);

    // Reset part-way through the first word, then the full program
    do_reset();
    send(8'hAA, 1'b0, 0);
    send(8'hBB, 1'b0, 0);
    do_reset();
    chk_reset_state("t5");
    for (int i = 0; i < 8; i++) send(prog[i], (i == 7), 0);
    step();
    chk("t5_nwrites", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() >= 2) begin
      chk("t5_addr0", 32'(wr_addr[0]), 32'd0);
      chk("t5_data0", wr_data[0], 32'h20080005);
      chk("t5_data1", wr_data[1], 32'h2009000A);
    end
    chk("t5_wc", 32'(word_count), 32'd2);
    chk("t5_done", {30'd0, done, error}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
